// File: rtl/quad_load_align.sv
// Sequential load aligner: shifts a RAM word right one byte per clock, then masks/extends to the access size.
// Optional sign extension (port sign_ext) is built only when QUAD_LOAD_ALIGN_SIGNEXT_EN is defined.
//
// state   | meaning
// IDLE    | ready for a request, in_ready = 1
// SHIFT   | shifting sh_q right one byte per cycle until cnt_q reaches zero
// DONE    | result held on data_out/oob until out_ready
module quad_load_align #(
   parameter int DATA_W = 64,
   parameter int OFF_W  = $clog2(DATA_W/8)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] data_in,
   input  logic [OFF_W-1:0]  offset,
   input  logic [1:0]        size,
`ifdef QUAD_LOAD_ALIGN_SIGNEXT_EN
   input  logic              sign_ext,
`endif
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] data_out,
   output logic              oob,
   output logic              busy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;
   localparam int NBYTES = DATA_W/8;

   logic [1:0]        state_q, state_d;
   logic [DATA_W-1:0] sh_q, sh_d;
   logic [OFF_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        size_q, size_d;
   logic              oob_q, oob_d;
   logic [DATA_W-1:0] dout_q, dout_d;
`ifdef QUAD_LOAD_ALIGN_SIGNEXT_EN
   logic              sx_q, sx_d;
   logic              fill;
`endif

   int                req_bytes;
   logic              req_oob;
   int                keep_bits;
   logic [DATA_W-1:0] keep_mask;
   logic [DATA_W-1:0] fmt_val;
   logic              accept;

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign data_out  = dout_q;
   assign oob       = oob_q;
   assign accept    = in_valid && in_ready;

   // Access sizes wider than the RAM word clamp to the full word.
   always_comb begin
      req_bytes = 1 << size;
      if (req_bytes > NBYTES) req_bytes = NBYTES;
      req_oob = (int'(offset) + req_bytes) > NBYTES;
   end

   always_comb begin
      keep_bits = 8 << size_q;
      if (keep_bits > DATA_W) keep_bits = DATA_W;
      keep_mask = ~({DATA_W{1'b1}} << keep_bits);
`ifdef QUAD_LOAD_ALIGN_SIGNEXT_EN
      // keep_mask ^ (keep_mask >> 1) isolates the sign bit position of the selected size.
      fill    = sx_q & (|(sh_q & (keep_mask ^ (keep_mask >> 1))));
      fmt_val = (sh_q & keep_mask) | ({DATA_W{fill}} & ~keep_mask);
`else
      fmt_val = sh_q & keep_mask;
`endif
   end

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      size_d  = size_q;
      oob_d   = oob_q;
      dout_d  = dout_q;
`ifdef QUAD_LOAD_ALIGN_SIGNEXT_EN
      sx_d    = sx_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               sh_d    = data_in;
               cnt_d   = offset;
               size_d  = size;
               oob_d   = req_oob;
`ifdef QUAD_LOAD_ALIGN_SIGNEXT_EN
               sx_d    = sign_ext;
`endif
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (cnt_q != '0) begin
               sh_d  = sh_q >> 8;
               cnt_d = cnt_q - OFF_W'(1);
            end else begin
               dout_d  = fmt_val;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         sh_q    <= '0;
         cnt_q   <= '0;
         size_q  <= '0;
         oob_q   <= 1'b0;
         dout_q  <= '0;
`ifdef QUAD_LOAD_ALIGN_SIGNEXT_EN
         sx_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
         size_q  <= size_d;
         oob_q   <= oob_d;
         dout_q  <= dout_d;
`ifdef QUAD_LOAD_ALIGN_SIGNEXT_EN
         sx_q    <= sx_d;
`endif
      end
   end

endmodule
